// File: rtl/fv_arith_pkg.sv
// Shared arithmetic definitions for the sequential divider and multiplier.
// Holds the common FSM state encoding and the default operand width.
package fv_arith_pkg;

  localparam int FV_ARITH_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } fv_state_e;

endpackage

// File: rtl/seq_mul_add.sv
// Sequential shift-and-add MAC: product = multiplicand * multiplier + addend.
// Ports: clk, rstn (async low), start, multiplicand/multiplier/addend [N],
//        product [2N], busy, done.  Option: SEQ_MUL_ADD_EARLY_EXIT_EN.
module seq_mul_add
  import fv_arith_pkg::*;
#(
  parameter int N = FV_ARITH_W
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic [N-1:0]   addend,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N + 1);

  fv_state_e state_q;
  fv_state_e state_d;

  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] mcand_q;
  logic [N-1:0]   mplier_q;
  logic [CW-1:0]  count_q;
  logic [2*N-1:0] product_q;
  logic           done_q;
  logic           last;

  // Final CALC iteration; early exit also stops once no set
  // multiplier bits remain after this shift.
  always_comb begin
    last = (count_q == CW'(1));
`ifdef SEQ_MUL_ADD_EARLY_EXIT_EN
    if (mplier_q[N-1:1] == '0) begin
      last = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_CALC;
      ST_CALC: if (last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            acc_q    <= {{N{1'b0}}, addend};
            mcand_q  <= {{N{1'b0}}, multiplicand};
            mplier_q <= multiplier;
            count_q  <= CW'(N);
          end
        end
        ST_CALC: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q - CW'(1);
        end
        ST_DONE: begin
          product_q <= acc_q;
          done_q    <= 1'b1;
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign product = product_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_mul_add.sv
// Scoreboard bench for seq_mul_add: reference products and completion
// edges are queued at issue and checked by an independent monitor.
module tb_seq_mul_add;

  localparam int N = 16;

  logic           clk;
  logic           rstn;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [N-1:0]   addend;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  seq_mul_add #(.N(N)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    longint unsigned val;
    int              due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Cycles from the start edge to the edge that raises done.
  function automatic int exp_lat(input longint unsigned b);
    int h;
`ifdef SEQ_MUL_ADD_EARLY_EXIT_EN
    h = 0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) h = i + 1;
    end
    if (h == 0) h = 1;
    return h + 1;
`else
    h = N;
    return h + 1;
`endif
  endfunction

  // Monitor: compares whenever done is presented.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_pulse: done high two cycles at cyc %0d", cyc);
      end
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got product %h, none pending",
                 product);
      end else begin
        e = q.pop_front();
        checks++;
        if (64'(product) != e.val) begin
          errors++;
          $display("FAIL product: got %h want %h", product, e.val);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL latency: done at edge %0d want %0d", cyc, e.due);
        end
      end
    end
    prev_done = done;
  end

  // Called in the low phase; the start is sampled at the next edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] c, output int s);
    exp_t e;
    s = cyc + 1;
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    start        = 1'b1;
    e.val = longint'(a) * longint'(b) + longint'(c);
    e.due = s + exp_lat(64'(b));
    q.push_back(e);
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = N'($urandom);
    multiplier   = N'($urandom);
    addend       = N'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results pending", q.size());
      q.delete();
    end
  endtask

  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic [N-1:0] c);
    int s;
    issue(a, b, c, s);
    wait_idle();
  endtask

  task automatic chk(input string nm, input longint unsigned got,
                     input longint unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  initial begin
    int s;
    logic [N-1:0] qq, dd, rr;
    rstn = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    addend = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_product", 64'(product), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_done", 64'(done), 0);
    rstn = 1'b1;
    @(negedge clk);
    #1;

    // Basic op with busy window tracking.
    issue(16'd1234, 16'd5678, 16'd9, s);
    chk("basic_ref", longint'(1234) * 5678 + 9, 64'h006AE9C5);
    for (int k = 1; k < 20 && cyc <= s + exp_lat(5678); k++) begin
      @(negedge clk);
      #1;
      chk("busy_window", 64'(busy),
          (cyc - s) < exp_lat(5678) ? 1 : 0);
    end
    wait_idle();

    run(16'hFFFF, 16'hFFFF, 16'hFFFF);
    run(16'd4, 16'd7, 16'd3);
    run(16'hABCD, 16'h0000, 16'h0042);
    run(16'h0001, 16'h8000, 16'h0000);

    // Start while busy is ignored; restart right after done.
    issue(16'd300, 16'd211, 16'd17, s);
    while (cyc < s + 4) begin
      @(negedge clk);
      #1;
    end
    multiplicand = 16'd55;
    multiplier   = 16'd66;
    addend       = 16'd77;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    chk("restart_edge", 64'(cyc - s), 64'(exp_lat(211)));
    issue(16'd999, 16'd1001, 16'd5, s);
    wait_idle();

    // Reset in the middle of an operation.
    issue(16'hBEEF, 16'hF00D, 16'h1234, s);
    while (cyc < s + 8) begin
      @(negedge clk);
      #1;
    end
    rstn = 1'b0;
    #1;
    chk("midreset_product", 64'(product), 0);
    chk("midreset_busy", 64'(busy), 0);
    chk("midreset_done", 64'(done), 0);
    q.delete();
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;
    repeat (25) begin
      @(negedge clk);
      #1;
    end
    chk("post_reset_quiet", 64'(product), 0);
    run(16'd321, 16'd123, 16'd7);

    // Random MAC and divider round-trip pairs.
    for (int i = 0; i < 20; i++) begin
      run(N'($urandom), N'($urandom), N'($urandom));
    end
    for (int i = 0; i < 10; i++) begin
      dd = N'($urandom_range(1, 65535));
      qq = N'($urandom);
      rr = N'($urandom_range(0, int'(dd) - 1));
      chk("div_model", (longint'(qq) * dd + rr) / dd, 64'(qq));
      run(qq, dd, rr);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
